ins_mem_loader: RTL and testbench



---
 rtl/ins_mem_loader.sv | 183 ++++++++++++++++++
 tb/tb_ins_mem_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_loader.sv
// Boot-time instruction-memory loader: receives a length-prefixed byte stream, writes
// big-endian words to consecutive addresses, verifies an XOR checksum and releases the CPU.
module ins_mem_loader #(
  parameter int unsigned MAX_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        InsMemRW,
  output logic [31:0] InsAddr,
  output logic [31:0] InsDataIn,
  output logic        CPURun,
  output logic        LoadErr,
  output logic [1:0]  ErrCode,
  output logic [15:0] WordCount
);

  typedef enum logic [2:0] {
    StWaitLenHi,
    StWaitLenLo,
    StData,
    StWrite,
    StWaitChk,
    StDone,
    StError
  } state_e;

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrLength   = 2'b01;
  localparam logic [1:0] ErrChecksum = 2'b10;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] word_q, word_d;
  logic [15:0] word_count_q, word_count_d;

  logic        rx_ready_q, rx_ready_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        run_q, run_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        xfer;
  logic [15:0] len_full;

  // The handshake uses the registered ready, so a byte only moves when RxReady was visible.
  assign xfer     = RxValid & rx_ready_q;
  assign len_full = {len_q[15:8], RxData};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    chk_d        = chk_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    err_code_d   = err_code_q;

    if (Start) begin
      state_d      = StWaitLenHi;
      byte_idx_d   = 2'd0;
      chk_d        = 8'h00;
      word_count_d = 16'd0;
      err_code_d   = ErrNone;
    end else begin
      unique case (state_q)
        StWaitLenHi: begin
          if (xfer) begin
            len_d   = {RxData, 8'h00};
            state_d = StWaitLenLo;
          end
        end
        StWaitLenLo: begin
          if (xfer) begin
            len_d = len_full;
            if ({16'd0, len_full} > MAX_WORDS) begin
              state_d    = StError;
              err_code_d = ErrLength;
            end else if (len_full == 16'd0) begin
              state_d = StWaitChk;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          if (xfer) begin
            word_d     = {word_q[23:0], RxData};
            chk_d      = chk_q ^ RxData;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_d = StWrite;
            end
          end
        end
        StWrite: begin
          word_count_d = word_count_q + 16'd1;
          if (word_count_q + 16'd1 == len_q) begin
            state_d = StWaitChk;
          end else begin
            state_d = StData;
          end
        end
        StWaitChk: begin
          if (xfer) begin
            if (RxData == chk_q) begin
              state_d = StDone;
            end else begin
              state_d    = StError;
              err_code_d = ErrChecksum;
            end
          end
        end
        StDone:  state_d = StDone;
        StError: state_d = StError;
        default: state_d = StWaitLenHi;
      endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    rx_ready_d = (state_d == StWaitLenHi) || (state_d == StWaitLenLo) ||
                 (state_d == StData) || (state_d == StWaitChk);
    mem_rw_d   = (state_d != StWrite);
    addr_d     = addr_q;
    data_d     = data_q;
    if (state_d == StWrite) begin
      addr_d = BASE_ADDR + {14'd0, word_count_d, 2'b00};
      data_d = word_d;
    end
    run_d = (state_d == StDone);
    err_d = (state_d == StError);
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q      <= StWaitLenHi;
      len_q        <= 16'd0;
      byte_idx_q   <= 2'd0;
      chk_q        <= 8'h00;
      word_q       <= 32'h0;
      word_count_q <= 16'd0;
      rx_ready_q   <= 1'b0;
      mem_rw_q     <= 1'b1;
      addr_q       <= BASE_ADDR;
      data_q       <= 32'h0;
      run_q        <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ErrNone;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      chk_q        <= chk_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
      rx_ready_q   <= rx_ready_d;
      mem_rw_q     <= mem_rw_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      run_q        <= run_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign RxReady   = rx_ready_q;
  assign InsMemRW  = mem_rw_q;
  assign InsAddr   = addr_q;
  assign InsDataIn = data_q;
  assign CPURun    = run_q;
  assign LoadErr   = err_q;
  assign ErrCode   = err_code_q;
  assign WordCount = word_count_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: table of whole loads plus hand-written abort/reset cases.
module tb_ins_mem_loader;

  localparam logic [31:0] Base = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        Reset, Start, RxValid;
  logic [7:0]  RxData;
  logic        RxReady, InsMemRW, CPURun, LoadErr;
  logic [31:0] InsAddr, InsDataIn;
  logic [1:0]  ErrCode;
  logic [15:0] WordCount;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  ins_mem_loader #(
    .MAX_WORDS(64),
    .BASE_ADDR(Base)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .RxData   (RxData),
    .RxValid  (RxValid),
    .RxReady  (RxReady),
    .InsMemRW (InsMemRW),
    .InsAddr  (InsAddr),
    .InsDataIn(InsDataIn),
    .CPURun   (CPURun),
    .LoadErr  (LoadErr),
    .ErrCode  (ErrCode),
    .WordCount(WordCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Record every write strobe; the loader must never offer ready while strobing.
  always @(negedge CLK) begin
    if (Reset === 1'b1 && InsMemRW === 1'b0) begin
      wr_addr.push_back(InsAddr);
      wr_data.push_back(InsDataIn);
      check("ready_in_write", {31'd0, RxReady}, 32'd0);
    end
  end

  function automatic logic [31:0] word_of(input int pat, input int i);
    case (pat)
      0:       return (i == 0) ? 32'h2001_0005 : 32'h2002_0007;
      1:       return 32'd1 << i;
      2:       return 32'hF000_0000 | 32'(i);
      default: return 32'h0;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit done = 0;
    int budget = 20;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        RxValid = 1'b0;
        RxData  = 8'($urandom);
        @(posedge CLK); #1;
      end
    end
    RxValid = 1'b1;
    RxData  = b;
    while (!done && budget > 0) begin
      @(negedge CLK);
      done = (RxReady === 1'b1);
      @(posedge CLK); #1;
      budget--;
    end
    RxValid = 1'b0;
    RxData  = 8'($urandom);
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL byte_accept: byte %h not accepted, expected acceptance within 20 cycles", b);
    end
  endtask

  // Start with a byte offered on the same cycle; that byte must be dropped.
  task automatic pulse_start();
    Start   = 1'b1;
    RxValid = 1'b1;
    RxData  = 8'hCC;
    @(posedge CLK); #1;
    Start   = 1'b0;
    RxValid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] len;
    int          pat;
    bit          body;
    logic [7:0]  chk;
    bit          gaps;
    int          exp_writes;
    bit          exp_run;
    bit          exp_err;
    logic [1:0]  exp_code;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t vec[8];

  initial begin
    // XOR of 20 01 00 05 20 02 00 07 is 0x01.
    vec[0] = '{16'd2,     0, 1'b1, 8'h01, 1'b0, 2,  1'b1, 1'b0, 2'd0, 16'd2};
    vec[1] = '{16'd2,     0, 1'b1, 8'h00, 1'b0, 2,  1'b0, 1'b1, 2'd2, 16'd2};
    vec[2] = '{16'd65,    0, 1'b0, 8'h00, 1'b0, 0,  1'b0, 1'b1, 2'd1, 16'd0};
    vec[3] = '{16'd0,     0, 1'b1, 8'h00, 1'b0, 0,  1'b1, 1'b0, 2'd0, 16'd0};
    vec[4] = '{16'd0,     0, 1'b1, 8'h01, 1'b0, 0,  1'b0, 1'b1, 2'd2, 16'd0};
    vec[5] = '{16'd8,     1, 1'b1, 8'hFF, 1'b1, 8,  1'b1, 1'b0, 2'd0, 16'd8};
    vec[6] = '{16'd64,    2, 1'b1, 8'h00, 1'b0, 64, 1'b1, 1'b0, 2'd0, 16'd64};
    vec[7] = '{16'h0140,  0, 1'b0, 8'h00, 1'b0, 0,  1'b0, 1'b1, 2'd1, 16'd0};

    Reset = 1'b0; Start = 1'b0; RxValid = 1'b0; RxData = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready",   {31'd0, RxReady},  32'd0);
    check("rst_rw",      {31'd0, InsMemRW}, 32'd1);
    check("rst_addr",    InsAddr,           Base);
    check("rst_data",    InsDataIn,         32'd0);
    check("rst_run",     {31'd0, CPURun},   32'd0);
    check("rst_err",     {31'd0, LoadErr},  32'd0);
    check("rst_code",    {30'd0, ErrCode},  32'd0);
    check("rst_wc",      {16'd0, WordCount}, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check("ready_after_rst", {31'd0, RxReady}, 32'd1);
    @(posedge CLK); #1;

    for (int r = 0; r < 8; r++) begin
      pulse_start();
      wr_addr.delete();
      wr_data.delete();
      send_byte(vec[r].len[15:8], vec[r].gaps);
      send_byte(vec[r].len[7:0], vec[r].gaps);
      if (vec[r].body) begin
        for (int w = 0; w < int'(vec[r].len); w++) begin
          for (int b = 0; b < 4; b++) begin
            send_byte(8'(word_of(vec[r].pat, w) >> (24 - 8 * b)), vec[r].gaps);
          end
        end
        send_byte(vec[r].chk, vec[r].gaps);
      end
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check($sformatf("v%0d_writes", r), 32'(wr_addr.size()), 32'(vec[r].exp_writes));
      for (int k = 0; k < vec[r].exp_writes && k < wr_addr.size(); k++) begin
        check($sformatf("v%0d_addr%0d", r, k), wr_addr[k], Base + 32'(4 * k));
        check($sformatf("v%0d_data%0d", r, k), wr_data[k], word_of(vec[r].pat, k));
      end
      check($sformatf("v%0d_run", r),   {31'd0, CPURun},    {31'd0, vec[r].exp_run});
      check($sformatf("v%0d_err", r),   {31'd0, LoadErr},   {31'd0, vec[r].exp_err});
      check($sformatf("v%0d_code", r),  {30'd0, ErrCode},   {30'd0, vec[r].exp_code});
      check($sformatf("v%0d_wc", r),    {16'd0, WordCount}, {16'd0, vec[r].exp_wc});
      check($sformatf("v%0d_ready", r), {31'd0, RxReady},   32'd0);
      check($sformatf("v%0d_rw", r),    {31'd0, InsMemRW},  32'd1);
      @(posedge CLK); #1;
    end

    // Abort two bytes into the first word, then a fresh single-word load.
    pulse_start();
    wr_addr.delete();
    wr_data.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    pulse_start();
    @(negedge CLK);
    check("abort_writes", 32'(wr_addr.size()), 32'd0);
    check("abort_wc",     {16'd0, WordCount}, 32'd0);
    check("abort_ready",  {31'd0, RxReady},   32'd1);
    check("abort_err",    {31'd0, LoadErr},   32'd0);
    @(posedge CLK); #1;
    // DE^AD^BE^EF = 0x22.
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reload_writes", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      check("reload_addr", wr_addr[0], Base);
      check("reload_data", wr_data[0], 32'hDEAD_BEEF);
    end
    check("reload_run", {31'd0, CPURun},    32'd1);
    check("reload_wc",  {16'd0, WordCount}, 32'd1);

    // Reset out of DONE.
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(negedge CLK);
    check("rstdone_run", {31'd0, CPURun},    32'd0);
    check("rstdone_rw",  {31'd0, InsMemRW},  32'd1);
    check("rstdone_wc",  {16'd0, WordCount}, 32'd0);
    @(posedge CLK); @(negedge CLK);
    check("rstdone_ready", {31'd0, RxReady}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
